// File: rtl/alu_serial_addsub.sv
// Multi-cycle adder/subtractor: DIGIT bits per cycle through a registered carry,
// valid/ready on both sides, NZCV flags registered alongside the result.
module alu_serial_addsub #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             c,
   output logic             v,
   output logic             z,
   output logic             n
);

   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N);

   generate
      if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
         $error("alu_serial_addsub: WIDTH must be a non-zero multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             c_q, c_d;
   logic             v_q, v_d;
   logic             z_q, z_d;
   logic             n_q, n_d;
   logic [DIGIT:0]   dsum;
   logic             fin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         diff_q  <= '0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         diff_q  <= diff_d;
         c_q     <= c_d;
         v_q     <= v_d;
         z_q     <= z_d;
         n_q     <= n_d;
      end
   end

   // RUN spends N cycles on digits plus one cycle publishing result and flags.
   assign fin = (state_q == RUN) && (cnt_q == LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = RUN;
         RUN:     if (fin)       state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      diff_d  = diff_q;
      c_d     = c_q;
      v_d     = v_q;
      z_d     = z_q;
      n_d     = n_q;
      dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a_in;
               b_d     = sub ? ~b_in : b_in;
               carry_d = cin ^ sub;
               cnt_d   = '0;
               a_msb_d = a_in[WIDTH-1];
               b_msb_d = sub ? ~b_in[WIDTH-1] : b_in[WIDTH-1];
            end
         end
         RUN: begin
            if (fin) begin
               diff_d = res_q;
               c_d    = carry_q;
               n_d    = res_q[WIDTH-1];
               z_d    = (res_q == '0);
               v_d    = (a_msb_q == b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
            end else begin
               // New digit enters at the top so after N steps digit 0 sits at the bottom.
               res_d   = (res_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
               a_d     = a_q >> DIGIT;
               b_d     = b_q >> DIGIT;
               carry_d = dsum[DIGIT];
               cnt_d   = cnt_q + CW'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      diff      = diff_q;
      c         = c_q;
      v         = v_q;
      z         = z_q;
      n         = n_q;
   end

endmodule
